alu_share_arbiter: RTL

- Shares the single 24-bit ALU (per-bit AND/OR/ADD/LESS result mux, 2-bit select) between two requesters: the main execute path (port 0) and the branch/compare unit (port 1).
- Arbitrates with round-robin priority and latches the winner's operands and opcode.
- Drives the ALU for one cycle, then registers the result and zero flag and returns them with a done pulse.
- Sits between the requesters and the combinational ALU; the ALU itself is unchanged.

---
 rtl/alu_share_arbiter_if.sv | 62 ++++++
 rtl/alu_share_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
//   Bundles the two requester ports, the shared-ALU drive/return signals and
//   the busy flag for alu_share_arbiter.
//   Port 0 (execute path) and port 1 (branch/compare unit):
//     reqX, opX[2:0], aX, bX        requester -> arbiter
//     gntX, doneX, resX, zeroX      arbiter -> requester
//   Shared ALU:
//     alu_a, alu_b, alu_sel[1:0], alu_bnegate   arbiter -> ALU
//     alu_result, alu_zero                      ALU -> arbiter
//   busy                                        arbiter status
//   The slave modport is the arbiter's view; the master modport is the
//   environment's (requesters plus ALU).
interface alu_share_arbiter_if #(
   parameter int unsigned WIDTH = 24
);
   logic             req0;
   logic [2:0]       op0;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic             gnt0;
   logic             done0;
   logic [WIDTH-1:0] res0;
   logic             zero0;

   logic             req1;
   logic [2:0]       op1;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic             gnt1;
   logic             done1;
   logic [WIDTH-1:0] res1;
   logic             zero1;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [1:0]       alu_sel;
   logic             alu_bnegate;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;

   logic             busy;

   modport slave (
      input  req0, op0, a0, b0,
      output gnt0, done0, res0, zero0,
      input  req1, op1, a1, b1,
      output gnt1, done1, res1, zero1,
      output alu_a, alu_b, alu_sel, alu_bnegate,
      input  alu_result, alu_zero,
      output busy
   );

   modport master (
      output req0, op0, a0, b0,
      input  gnt0, done0, res0, zero0,
      output req1, op1, a1, b1,
      input  gnt1, done1, res1, zero1,
      input  alu_a, alu_b, alu_sel, alu_bnegate,
      output alu_result, alu_zero,
      input  busy
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between the execute path (port 0) and the
//   branch/compare unit (port 1). Round-robin arbitration in IDLE, one EXEC
//   cycle driving the ALU from latched operands, one RESP cycle pulsing the
//   owner's done with its registered result and zero flag.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    alu_share_arbiter_if.slave (requesters, ALU drive/return, busy)
module alu_share_arbiter #(
   parameter int unsigned WIDTH = 24
) (
   input  logic                clk,
   input  logic                reset,
   alu_share_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             ptr_q;      // 1: port 1 wins a tie
   logic             owner_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] res0_q, res1_q;
   logic             zero0_q, zero1_q;
   logic             win0, win1;

   always_comb begin
      state_d = state_q;
      win0    = 1'b0;
      win1    = 1'b0;
      unique case (state_q)
         IDLE: begin
            win0 = bus.req0 & (~bus.req1 | ~ptr_q);
            win1 = bus.req1 & (~bus.req0 |  ptr_q);
            if (win0 | win1)
               state_d = EXEC;
         end
         EXEC:    state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         owner_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res0_q  <= '0;
         res1_q  <= '0;
         zero0_q <= 1'b0;
         zero1_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (win0) begin
            a_q     <= bus.a0;
            b_q     <= bus.b0;
            op_q    <= bus.op0;
            owner_q <= 1'b0;
            ptr_q   <= 1'b1;
         end else if (win1) begin
            a_q     <= bus.a1;
            b_q     <= bus.b1;
            op_q    <= bus.op1;
            owner_q <= 1'b1;
            ptr_q   <= 1'b0;
         end
         // The ALU output settles during EXEC; capture it for the owner only.
         if (state_q == EXEC) begin
            if (owner_q) begin
               res1_q  <= bus.alu_result;
               zero1_q <= bus.alu_zero;
            end else begin
               res0_q  <= bus.alu_result;
               zero0_q <= bus.alu_zero;
            end
         end
      end
   end

   assign bus.gnt0        = win0;
   assign bus.gnt1        = win1;
   assign bus.done0       = (state_q == RESP) & ~owner_q;
   assign bus.done1       = (state_q == RESP) &  owner_q;
   assign bus.res0        = res0_q;
   assign bus.zero0       = zero0_q;
   assign bus.res1        = res1_q;
   assign bus.zero1       = zero1_q;
   assign bus.alu_a       = a_q;
   assign bus.alu_b       = b_q;
   assign bus.alu_sel     = op_q[1:0];
   assign bus.alu_bnegate = op_q[2];
   assign bus.busy        = (state_q != IDLE);

endmodule
